uart_rx_frontend: RTL
=====================

Name: uart_rx_frontend

Overview:
- Serial receive front end feeding the Peripheral block's UART receive data/status registers (read at 0x4000001c).
- Synchronizes the asynchronous UART_RX pin and oversamples it 16x.
- Deframes 8N1 characters, LSB first, into a one-entry holding register with valid, framing-error and overrun flags.
- Pulses rx_irq once per accepted byte for the interrupt logic.

Parameters:
- CLK_FREQ, 100_000_000: sysclk frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- OVERSAMPLE, 16: ticks per bit time. Must be even and ≥ 8.
- DIV, CLK_FREQ/(BAUD*OVERSAMPLE) rounded to nearest (651 at defaults): sysclk cycles per tick. Derived localparam, must be ≥ 2.

Ports:
- sysclk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- UART_RX, input, 1: serial line, idle high, asynchronous to sysclk.
- rx_ack, input, 1: one-cycle pulse from the Peripheral read decode of 0x4000001c. Clears rx_valid, frame_err and overrun.
- rx_data, output, 8: last accepted byte.
- rx_valid, output, 1: rx_data holds an unread byte.
- frame_err, output, 1: sticky. Last character had a 0 stop bit.
- overrun, output, 1: sticky. A byte was accepted while rx_valid was already 1.
- rx_irq, output, 1: one-cycle pulse when a byte is accepted.

Behaviour:
- Reset (reset=0, asynchronous): rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, rx_irq=0. State=IDLE, counters=0, synchronizer flops=1. Reset mid-character aborts that character with no flag set.
- Synchronizer: 2 flops; rx_s is the second flop. This adds 2 cycles of latency from pin to FSM.
- Tick generator: counts 0..DIV-1 and emits tick=1 for one cycle at DIV-1. It is held at 0 in IDLE, so ticks are phase-aligned to start detection.
- Per-state operation (tick_cnt counts ticks; bit_cnt counts data bits):
  - IDLE: rx_s==0 → START, tick_cnt=0.
  - START: on tick, tick_cnt++. When tick_cnt reaches OVERSAMPLE/2-1 (mid start bit):
    - rx_s==1 → IDLE (glitch rejected, no flags).
    - rx_s==0 → DATA, tick_cnt=0, bit_cnt=0.
  - DATA: when tick_cnt reaches OVERSAMPLE-1 (mid bit), shift right: sh = {rx_s, sh[7:1]}, bit_cnt++, tick_cnt=0. After bit_cnt==7 is sampled → STOP.
  - STOP: at mid stop bit (tick_cnt==OVERSAMPLE-1):
    - rx_s==1 → accept. Next cycle: rx_data=sh, rx_valid=1, rx_irq=1 for one cycle. If rx_valid was already 1 and rx_ack is not asserted in this cycle, overrun=1 and the new byte overwrites. → IDLE.
    - rx_s==0 → frame_err=1; rx_data, rx_valid and rx_irq unchanged → BREAK.
  - BREAK: wait for rx_s==1, then → IDLE. A held-low line therefore yields exactly one frame_err and no spurious bytes.
- Latency: rx_valid rises 1 sysclk after the stop-bit mid-sample tick. That is about 9.5 bit times plus 3 cycles after the falling edge on the pin.
- rx_ack alone: next cycle rx_valid=0, frame_err=0, overrun=0. rx_data is retained.
- rx_ack in the same cycle as accept: the accept wins. rx_valid stays 1, rx_data is the new byte, overrun is not set, and frame_err clears.
- rx_ack in the same cycle as a framing error: frame_err ends at 1.
- Back-to-back characters: a start edge detected in IDLE immediately after STOP is accepted. There is no extra idle requirement beyond the half stop bit remaining.
- Counter widths: $clog2(DIV), $clog2(OVERSAMPLE), 3-bit bit_cnt. All counters wrap only via explicit clear.

Decomposition:
- Shared package uart_pkg holds:
  - state enum: IDLE, START, DATA, STOP, BREAK;
  - the 8N1 constants DATA_BITS=8 and STOP_LEVEL=1;
  - the function computing DIV from CLK_FREQ, BAUD and OVERSAMPLE.
- One sub-module, uart_baud_tick (parameter DIV; inputs sysclk, reset, en; output tick), is shared with the future transmitter.

Test Plan (sim parameters CLK_FREQ=1_600_000, BAUD=10_000 → DIV=10, 160 cycles/bit):
- Drive 8N1 byte 0xA5 → rx_data=0xA5, rx_valid=1, rx_irq high exactly 1 cycle, frame_err=0, overrun=0.
- Low glitch of 40 cycles on an idle line → no rx_irq, rx_valid stays 0, FSM back in IDLE; a following 0x3C is received correctly.
- Byte 0x3C with stop bit 0, line then returned high → frame_err=1, rx_valid=0, rx_data unchanged (0x00 after reset). rx_ack → frame_err=0.
- Bytes 0x11 then 0x22 back-to-back, no rx_ack → rx_data=0x22, rx_valid=1, overrun=1. rx_ack → rx_valid=0, overrun=0, rx_data=0x22.
- rx_ack forced in the accept cycle of 0x0F while rx_valid=1 → rx_valid=1, rx_data=0x0F, overrun=0.
- reset pulled low during bit 4 of 0x55 → all outputs 0 immediately. After release, 0xF0 is received with no flags.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding, 8N1 frame constants and the baud divider calculation.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    localparam int DATA_BITS = 8;
    localparam logic STOP_LEVEL = 1'b1;
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return (clk_freq + baud * oversample / 2) / (baud * oversample);
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle tick every DIV cycles while enabled; held at zero when idle.
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic sysclk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(DIV);
    logic [W-1:0] cnt;
    assign tick = cnt == W'(DIV - 1);
    always_ff @(posedge sysclk or negedge reset)
        if (!reset) cnt <= '0;
        else cnt <= (!en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: synchronised, oversampled 8N1 receiver feeding a one-entry holding register
// with valid, sticky framing-error and sticky overrun flags.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       UART_RX,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_irq
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    state_t state, next;
    logic [1:0] sync;
    logic rx_s, tick, at_half, at_last, sample, accept, ferr;
    logic [TW-1:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] sh;
    assign rx_s = sync[1];
    uart_baud_tick #(.DIV(DIV)) u_tick (
        .sysclk(sysclk),
        .reset(reset),
        .en(state != IDLE),
        .tick(tick)
    );
    assign at_half = tick && tick_cnt == HALF;
    assign at_last = tick && tick_cnt == LAST;
    assign sample  = state == DATA && at_last;
    assign accept  = state == STOP && at_last && rx_s == STOP_LEVEL;
    assign ferr    = state == STOP && at_last && rx_s != STOP_LEVEL;
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = rx_s ? IDLE : START;
            START:   if (at_half) next = rx_s ? IDLE : DATA;
            DATA:    if (sample && bit_cnt == 3'(DATA_BITS - 1)) next = STOP;
            STOP:    if (at_last) next = accept ? IDLE : BREAK;
            BREAK:   if (rx_s) next = IDLE;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge sysclk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= next;
    // START counts only to mid start bit; DATA/STOP count a full bit so samples land mid-bit
    always_ff @(posedge sysclk or negedge reset)
        if (!reset) begin
            sync     <= 2'b11;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            sh       <= '0;
        end else begin
            sync     <= {sync[0], UART_RX};
            tick_cnt <= (state == IDLE || (state == START ? at_half : at_last)) ? '0 : tick_cnt + TW'(tick);
            bit_cnt  <= state != DATA ? 3'd0 : bit_cnt + 3'(sample);
            if (sample) sh <= {rx_s, sh[7:1]};
        end
    // an accept outranks a simultaneous ack; a framing error outranks the ack's clear
    always_ff @(posedge sysclk or negedge reset)
        if (!reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rx_irq    <= 1'b0;
        end else begin
            rx_irq    <= accept;
            if (accept) rx_data <= sh;
            rx_valid  <= accept || (rx_valid && !rx_ack);
            overrun   <= !rx_ack && (overrun || (accept && rx_valid));
            frame_err <= ferr || (frame_err && !rx_ack);
        end
endmodule
